// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the display scan, with slot/frame markers.
module seg_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             slot_start,
  output logic             blank_end,
  output logic             slot_end,
  output logic             frame_end,
  output logic             frame_pre
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_BEND = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign slot_start = (cnt == '0);
  assign blank_end  = (BLANK_CYC > 0) && (cnt == CNT_BEND);
  assign slot_end   = (cnt == CNT_LAST);
  assign frame_end  = slot_end && (idx == IDX_LAST);
  // Lookahead: the next cycle is the final cycle of the frame.
  assign frame_pre  = run && (cnt == CNT_PRE) && (idx == IDX_LAST);

  always_comb begin
    cnt_nxt = cnt;
    idx_nxt = idx;
    if (clr) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (run) begin
      if (slot_end) begin
        cnt_nxt = '0;
        idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with anti-ghost blanking
// and frame-aligned double-buffered display contents.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] wr_digits,
  input  logic [NUM_DIGITS-1:0]         wr_dp,
  input  logic [NUM_DIGITS-1:0]         wr_blank,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic [DIGIT_W-1:0]            nibble,
  output logic                          dp,
  output logic                          frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e state, state_n;

  logic             run, clr;
  logic [IDX_W-1:0] idx, idx_n;
  logic             slot_start, blank_end, slot_end, frame_end, frame_pre;

  logic                          pend_flag, pend_flag_n, take, copy;
  logic [DIGIT_W*NUM_DIGITS-1:0] pend_dig, act_dig, act_dig_n;
  logic [NUM_DIGITS-1:0]         pend_dp, act_dp, act_dp_n;
  logic [NUM_DIGITS-1:0]         pend_blank, act_blank, act_blank_n;

  logic                  show_n, vis_n, dp_n;
  logic [NUM_DIGITS-1:0] dig_sel_n;
  logic [DIGIT_W-1:0]    nibble_n;

  assign run = en && (state != IDLE);
  assign clr = !en;

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clr        (clr),
    .idx        (idx),
    .idx_nxt    (idx_n),
    .slot_start (slot_start),
    .blank_end  (blank_end),
    .slot_end   (slot_end),
    .frame_end  (frame_end),
    .frame_pre  (frame_pre)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en && slot_start) state_n = (BLANK_CYC == 0) ? SHOW : BLANK;
      BLANK:   if (blank_end) state_n = SHOW;
      SHOW:    if (slot_end) state_n = (BLANK_CYC == 0) ? SHOW : BLANK;
      default: state_n = IDLE;
    endcase
    if (!en) state_n = IDLE;
  end

  // Pending contents move to active at a frame boundary, or at once when idle.
  assign take = wr_valid && wr_ready;
  assign copy = pend_flag && ((state == IDLE) || ((state == SHOW) && frame_end));

  always_comb begin
    pend_flag_n = pend_flag;
    if (take)      pend_flag_n = 1'b1;
    else if (copy) pend_flag_n = 1'b0;
    act_dig_n   = copy ? pend_dig   : act_dig;
    act_dp_n    = copy ? pend_dp    : act_dp;
    act_blank_n = copy ? pend_blank : act_blank;
  end

  // Outputs are registered from next-state values so they line up with the state register.
  always_comb begin
    show_n    = (state_n == SHOW);
    vis_n     = show_n && !act_blank_n[idx_n];
    dig_sel_n = vis_n ? NUM_DIGITS'(digit_onehot(3'(idx_n))) : '0;
    dp_n      = vis_n && act_dp_n[idx_n];
    nibble_n  = show_n ? act_dig_n[idx_n*DIGIT_W +: DIGIT_W] : nibble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_flag  <= 1'b0;
      wr_ready   <= 1'b1;
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      act_dig    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      dig_sel    <= '0;
      nibble     <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state     <= state_n;
      pend_flag <= pend_flag_n;
      wr_ready  <= !pend_flag_n;
      if (take) begin
        pend_dig   <= wr_digits;
        pend_dp    <= wr_dp;
        pend_blank <= wr_blank;
      end
      act_dig    <= act_dig_n;
      act_dp     <= act_dp_n;
      act_blank  <= act_blank_n;
      dig_sel    <= dig_sel_n;
      nibble     <= nibble_n;
      dp         <= dp_n;
      frame_done <= frame_pre;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a blanking build and a no-blank build.
module tb_seven_seg_scan_ctrl;

  typedef struct packed {
    int          cyc;
    logic [3:0]  ds;
    logic [3:0]  nib;
    logic        dp;
    logic        fd;
    logic        rdy;
    logic [63:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, wr_valid = 1'b0;
  logic [15:0] wr_digits = '0;
  logic [3:0]  wr_dp = '0, wr_blank = '0;
  logic        wr_ready, dp, frame_done;
  logic [3:0]  dig_sel, nibble;

  logic        en_b = 1'b0, wr_valid_b = 1'b0;
  logic [15:0] wr_digits_b = '0;
  logic [3:0]  wr_dp_b = '0, wr_blank_b = '0;
  logic        wr_ready_b, dp_b, frame_done_b;
  logic [3:0]  dig_sel_b, nibble_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_digits(wr_digits), .wr_dp(wr_dp), .wr_blank(wr_blank),
    .dig_sel(dig_sel), .nibble(nibble), .dp(dp), .frame_done(frame_done)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
    .wr_digits(wr_digits_b), .wr_dp(wr_dp_b), .wr_blank(wr_blank_b),
    .dig_sel(dig_sel_b), .nibble(nibble_b), .dp(dp_b), .frame_done(frame_done_b)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [63:0] tag, input int c, input logic [10:0] got,
                     input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got ds=%b nib=%h dp=%b fd=%b rdy=%b want ds=%b nib=%h dp=%b fd=%b rdy=%b",
               tag, c, got[10:7], got[6:3], got[2], got[1], got[0],
               want[10:7], want[6:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic push_one(input bit b, input int c, input logic [3:0] ds, input logic [3:0] nib,
                          input logic dpv, input logic fd, input logic rdy, input logic [63:0] tag);
    exp_t e;
    e.cyc = c; e.ds = ds; e.nib = nib; e.dp = dpv; e.fd = fd; e.rdy = rdy; e.tag = tag;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Expected scan of 8-cycle slots over 4 digits; wr_ready low for frame offsets lo_from..lo_to.
  task automatic push_frame(input bit b, input int start, input int ncyc, input logic [15:0] dig,
                            input logic [3:0] blk, input logic [3:0] dpv, input logic [3:0] prev_nib,
                            input int bc, input int lo_from, input int lo_to, input logic [63:0] tag);
    for (int k = 0; k < ncyc; k++) begin
      int d, p;
      logic on;
      logic [3:0] ds, nib;
      d  = (k / 8) % 4;
      p  = k % 8;
      on = (p >= bc);
      ds = (on && !blk[d]) ? 4'(1 << d) : 4'b0000;
      if (on)          nib = dig[d*4 +: 4];
      else if (d != 0) nib = dig[(d-1)*4 +: 4];
      else             nib = (k < 32) ? prev_nib : dig[15:12];
      push_one(b, start + k, ds, nib, on && dpv[d] && !blk[d], (k % 32) == 31,
               !(k >= lo_from && k <= lo_to), tag);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write_a(input int x, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    wait_cyc(x - 1);
    wr_valid = 1'b1; wr_digits = d; wr_blank = b; wr_dp = p;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      ea = qa.pop_front();
      chk(ea.tag, ea.cyc, {dig_sel, nibble, dp, frame_done, wr_ready},
          {ea.ds, ea.nib, ea.dp, ea.fd, ea.rdy});
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      eb = qb.pop_front();
      chk(eb.tag, eb.cyc, {dig_sel_b, nibble_b, dp_b, frame_done_b, wr_ready_b},
          {eb.ds, eb.nib, eb.dp, eb.fd, eb.rdy});
    end
  end

  initial begin
    #100000;
    $display("FAIL WATCHDOG cyc=%0d got no finish want finish", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int c0, x, s, r, c, y;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    push_one(0, c0 + 1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, "RESET_A ");
    push_one(1, c0 + 1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, "RESET_B ");

    // Load 1234 while disabled: accepted, then applied immediately.
    x = c0 + 3;
    push_one(0, x,     4'h0, 4'h0, 1'b0, 1'b0, 1'b0, "WRIDLE  ");
    push_one(0, x + 1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, "WRIDLE  ");
    write_a(x, 16'h1234, 4'b0000, 4'b0000);
    wait_cyc(x + 1);
    en = 1'b1;
    s = x + 2;
    push_frame(0, s,      32, 16'h1234, 4'b0000, 4'b0000, 4'h0, 2, 10, 31, "F1_1234 ");
    push_frame(0, s + 32, 32, 16'hABCD, 4'b0000, 4'b0000, 4'h1, 2,  5, 31, "F2_ABCD ");
    push_frame(0, s + 64, 32, 16'h5678, 4'b0100, 4'b0001, 4'hA, 2,  5, 31, "F3_BLANK");
    push_frame(0, s + 96, 20, 16'h5678, 4'b0000, 4'b0001, 4'h5, 2, -1, -2, "F4_DROP ");
    write_a(s + 10, 16'hABCD, 4'b0000, 4'b0000);
    write_a(s + 37, 16'h5678, 4'b0100, 4'b0001);
    write_a(s + 69, 16'h5678, 4'b0000, 4'b0001);

    // Disable during digit 2 SHOW, then re-enable.
    wait_cyc(s + 115);
    en = 1'b0;
    for (int i = 116; i <= 118; i++)
      push_one(0, s + i, 4'h0, 4'h6, 1'b0, 1'b0, 1'b1, "IDLE_EN0");
    wait_cyc(s + 118);
    en = 1'b1;
    r = s + 119;
    push_frame(0, r, 12, 16'h5678, 4'b0000, 4'b0001, 4'h6, 2, 4, 11, "F5_RESTA");
    write_a(r + 4, 16'h9999, 4'b0000, 4'b0000);

    // Asynchronous reset mid-SHOW with pending data.
    wait_cyc(r + 12);
    chk("PRE_RST ", cyc, {dig_sel, nibble, dp, frame_done, wr_ready}, {4'b0010, 4'h7, 3'b000});
    #2 rst = 1'b1;
    #1 chk("ASYNCRST", cyc, {dig_sel, nibble, dp, frame_done, wr_ready}, {4'b0000, 4'h0, 3'b001});
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    push_frame(0, c + 1, 34, 16'h0000, 4'b1111, 4'b0000, 4'h0, 2, -1, -2, "F6_DARK ");
    wait_cyc(c + 34);
    en = 1'b0;

    // No-blank build: contiguous visible slots.
    y = cyc + 2;
    push_one(1, y,     4'h0, 4'h0, 1'b0, 1'b0, 1'b0, "B_WRITE ");
    push_one(1, y + 1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, "B_WRITE ");
    wait_cyc(y - 1);
    wr_valid_b = 1'b1; wr_digits_b = 16'h1234; wr_blank_b = 4'b0000; wr_dp_b = 4'b0000;
    @(negedge clk);
    wr_valid_b = 1'b0;
    wait_cyc(y + 1);
    en_b = 1'b1;
    push_frame(1, y + 2, 64, 16'h1234, 4'b0000, 4'b0000, 4'h0, 0, -1, -2, "B_NOBLNK");

    for (int i = 0; i < 200 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL TIMEOUT got %0d/%0d pending want 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
